behav_counter: RTL and testbench
================================

// Module: behav_counter
//
// PURPOSE
//   Free-running, enable-gated binary up-counter with a terminal-count/overflow flag.
//   It is the behavioural implementation of the team's 8-bit counter block.
//   It is used as a timebase or event counter.
//   ovf is combinational so that counters can be cascaded (ovf of stage N drives en of stage N+1).
//
// PARAMETERS
//   WIDTH      8    counter width in bits; the range is 2..32
//   MAX_COUNT  255  terminal value; the counter wraps to 0 after it; the range is 1..2**WIDTH-1
//
// PORTS
//   clk    in   1      system clock; all state updates on the rising edge
//   rst    in   1      asynchronous, active-high reset
//   en     in   1      count enable; sampled on the rising edge of clk
//   count  out  WIDTH  current count value; registered output
//   ovf    out  1      terminal-count/overflow flag; combinational
//
// BEHAVIOUR
//   - The block has one clock domain (clk). Reset is asynchronous and active-high (rst).
//   - Reset:
//       - While rst=1, count=0 immediately, with no clock edge needed.
//       - While rst=1, ovf=0, independent of en.
//       - Reset has priority over en on every edge.
//   - Counting, on each rising edge of clk with rst=0:
//       - en=0: count holds its value.
//       - en=1 and count<MAX_COUNT: count <= count+1.
//       - en=1 and count==MAX_COUNT: count <= 0 (wrap).
//   - Latency: en sampled high at edge k gives the new count value just after edge k.
//   - ovf = (count==MAX_COUNT) & en & ~rst.
//       - ovf is high during the one cycle in which the next edge will wrap the counter.
//       - ovf has no register stage and no latency.
//   - count values above MAX_COUNT are unreachable.
//       - If MAX_COUNT < 2**WIDTH-1, upper codes never appear.
//       - If count ever sits above MAX_COUNT, the next enabled edge loads 0 (defensive wrap).
//   - Arithmetic is unsigned, modulo MAX_COUNT+1. There is no saturation and no down-count.
//   - Reset mid-count: count clears asynchronously at once.
//       - Counting resumes from 0 at the first rising edge with rst=0 and en=1.
//   - Reset deassertion coincident with a rising edge: that edge is a reset edge.
//       - count stays 0 after that edge.
//       - The first increment occurs on the following edge.
//   - en toggling has no side effects; the count is fully preserved while en=0.
//   - There is no X-propagation from en during reset; outputs stay defined.
//
// TESTING (clk period 10 ns, defaults WIDTH=8, MAX_COUNT=255)
//   1. Hold rst=1 for 100 ns, en=0, then release.
//      -> count=0 and ovf=0 throughout; count is still 0 after release with en=0.
//   2. After reset, set en=1 for 10 edges.
//      -> count steps 1,2,...,10, one per edge; ovf=0.
//   3. Keep en=1 through 256 edges from 0.
//      -> count reaches 255.
//      -> ovf=1 only while count=255.
//      -> the next edge gives count=0 and ovf=0; repeats every 256 edges.
//   4. Drop en to 0 at count=37 for 5 edges, then raise it again.
//      -> count holds 37; the next enabled edge gives 38.
//      -> at count=255 with en=0, ovf=0.
//   5. Assert rst between clock edges at count=100.
//      -> count=0 and ovf=0 before the next edge.
//      -> after release with en=1, count goes 1,2,...
//   6. Parameter run with WIDTH=4, MAX_COUNT=9.
//      -> the sequence is 0..9,0.
//      -> ovf=1 only during count=9 with en=1.

Source files
------------

// File: rtl/behav_counter.sv
// behav_counter: enable-gated binary up-counter that wraps to 0 after MAX_COUNT, with a terminal-count flag.
// Latency: count updates on the edge that samples en high; ovf is combinational (zero latency).
// Backpressure: none; en low simply holds the count, and ovf is suppressed while en is low or rst is high.
module behav_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             ovf
);

   // Terminal value expressed at counter width for like-for-like compares.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             at_max;

   assign at_max = (count_q == MAX_VAL);

   // Next-count: hold when idle, increment, or wrap; codes above the terminal value also fold back to 0.
   always_comb begin
      count_d = count_q;
      if (en) begin
         if (count_q >= MAX_VAL) begin
            count_d = '0;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   // Count register; reset clears it at once without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   // Flag the cycle whose next edge wraps the counter; kept combinational so stages can cascade.
   assign ovf   = at_max & en & ~rst;

endmodule

// File: tb/tb_behav_counter.sv
module tb_behav_counter;

   localparam int unsigned A_W   = 8;
   localparam int unsigned A_MAX = 255;
   localparam int unsigned B_W   = 4;
   localparam int unsigned B_MAX = 9;

   logic             clk = 1'b0;
   logic             rst_a = 1'b1;
   logic             en_a = 1'b0;
   logic [A_W-1:0]   count_a;
   logic             ovf_a;
   logic             rst_b = 1'b1;
   logic             en_b = 1'b0;
   logic [B_W-1:0]   count_b;
   logic             ovf_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference counts: plain modulo arithmetic on integers.
   int unsigned mdl_a = 0;
   int unsigned mdl_b = 0;

   behav_counter #(.WIDTH(A_W), .MAX_COUNT(A_MAX)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .count(count_a), .ovf(ovf_a)
   );

   behav_counter #(.WIDTH(B_W), .MAX_COUNT(B_MAX)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .count(count_b), .ovf(ovf_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on each edge, reset wins, else enabled edges advance modulo MAX+1.
   always @(posedge clk) begin
      if (rst_a) mdl_a = 0;
      else if (en_a) mdl_a = (mdl_a + 1) % (A_MAX + 1);
      if (rst_b) mdl_b = 0;
      else if (en_b) mdl_b = (mdl_b + 1) % (B_MAX + 1);
   end

   // Compare on the falling edge, away from the active edge and after the mid-cycle input changes.
   always @(negedge clk) begin
      chk("a_count", 32'(count_a), rst_a ? 32'd0 : mdl_a);
      chk("a_ovf",   32'(ovf_a),   32'(!rst_a && en_a && mdl_a == A_MAX));
      chk("b_count", 32'(count_b), rst_b ? 32'd0 : mdl_b);
      chk("b_ovf",   32'(ovf_b),   32'(!rst_b && en_b && mdl_b == B_MAX));
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held ~100 ns with en low.
      repeat (10) edge1();
      chk("rst_count", 32'(count_a), 32'd0);
      chk("rst_ovf", 32'(ovf_a), 32'd0);
      rst_a = 1'b0;
      repeat (2) edge1();
      chk("post_rst_idle", 32'(count_a), 32'd0);

      // First ten enabled edges step 1..10.
      en_a = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         edge1();
         chk("step", 32'(count_a), 32'(i));
         chk("step_ovf", 32'(ovf_a), 32'd0);
      end

      // Run to the terminal value.
      repeat (245) edge1();
      chk("term_count", 32'(count_a), 32'd255);
      chk("term_ovf", 32'(ovf_a), 32'd1);
      en_a = 1'b0;
      #1 chk("term_ovf_en0", 32'(ovf_a), 32'd0);
      edge1();
      chk("term_hold", 32'(count_a), 32'd255);
      en_a = 1'b1;
      edge1();
      chk("wrap_count", 32'(count_a), 32'd0);
      chk("wrap_ovf", 32'(ovf_a), 32'd0);

      // Hold at 37 for five idle edges.
      repeat (37) edge1();
      en_a = 1'b0;
      repeat (5) edge1();
      chk("hold37", 32'(count_a), 32'd37);
      en_a = 1'b1;
      edge1();
      chk("resume38", 32'(count_a), 32'd38);

      // Mid-cycle reset at 100.
      repeat (62) edge1();
      chk("at100", 32'(count_a), 32'd100);
      #2 rst_a = 1'b1;
      #1 chk("async_clr", 32'(count_a), 32'd0);
      chk("async_ovf", 32'(ovf_a), 32'd0);
      edge1();
      rst_a = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         edge1();
         chk("restart", 32'(count_a), 32'(i));
      end

      // Narrow instance: 0..9 then wrap.
      rst_b = 1'b0;
      en_b  = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         chk("b_ovf_lit", 32'(ovf_b), 32'((i - 1) % 10 == 9));
         edge1();
         chk("b_seq", 32'(count_b), 32'(i % 10));
      end

      // Randomised enables and occasional resets on both instances.
      for (int i = 0; i < 3000; i++) begin
         edge1();
         en_a  = ($urandom_range(3) != 0);
         en_b  = ($urandom_range(3) != 0);
         rst_a = ($urandom_range(199) == 0);
         rst_b = ($urandom_range(149) == 0);
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) edge1();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
